mem_port_arbiter: RTL and testbench

- Shares one unified memory port between the core's instruction-fetch requester (read-only) and data requester (load/store).
- Sits between the core and the single-ported memory model/BRAM wrapper. Replaces the separate instruction and data memories once the design moves to a unified memory.
- Handles one outstanding transaction at a time.
- Data port has priority. A starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch (i_*), data (d_*) and unified memory (m_*) port bundle.
// master: arbiter side. slave: requesters plus memory side.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  modport master (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata, i_err,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output m_req, m_we, m_addr, m_wdata, m_be,
    input  m_gnt, m_rvalid, m_rdata
  );

  modport slave (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  m_req, m_we, m_addr, m_wdata, m_be,
    output m_gnt, m_rvalid, m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (i_*) and data (d_*), one
// transaction in flight. Ports: clk, rst (sync, active high), bus
// (fetch/data/memory bundle, master modport), busy (state != IDLE).
// Data has priority; a starvation counter forces a fetch win after
// STARVE_LIMIT data wins. MEM_ARB_TIMEOUT_EN adds an error completion
// after TIMEOUT_CYCLES cycles in ISSUE+WAIT.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef enum logic {
    OWN_DATA,
    OWN_FETCH
  } owner_t;

  if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15 ||
      TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("mem_port_arbiter: illegal parameter");
  end

  state_t      state;
  owner_t      owner;
  logic [3:0]  starve_cnt;

  logic        m_req_q;
  logic        m_we_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_wdata_q;
  logic [3:0]  m_be_q;

  logic        starved;
  logic        fetch_win;
  logic        data_win;
  logic        resp_ok;
  logic        tmo;
  logic        done;
  logic [31:0] resp_data;

  assign starved   = (starve_cnt == 4'(STARVE_LIMIT));
  assign fetch_win = (state == IDLE) & bus.i_req &
                     (~bus.d_req | starved);
  assign data_win  = (state == IDLE) & bus.d_req & ~fetch_win;

  assign resp_ok   = (state == WAIT) & bus.m_rvalid;
  assign done      = resp_ok | tmo;
  assign resp_data = tmo ? 32'h0 : bus.m_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  // Held at zero in IDLE, so it starts from zero on ISSUE entry.
  assign tmo = (state != IDLE) &
               (tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  assign bus.i_gnt    = fetch_win;
  assign bus.d_gnt    = data_win;
  assign bus.i_rvalid = done & (owner == OWN_FETCH);
  assign bus.d_rvalid = done & (owner == OWN_DATA);
  assign bus.i_rdata  = resp_data;
  assign bus.d_rdata  = resp_data;
  assign bus.i_err    = tmo & (owner == OWN_FETCH);
  assign bus.d_err    = tmo & (owner == OWN_DATA);

  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.m_be     = m_be_q;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_DATA;
      starve_cnt <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_be_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.i_req || fetch_win) begin
            starve_cnt <= '0;
          end else if (data_win && !starved) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
          if (fetch_win) begin
            owner     <= OWN_FETCH;
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= bus.i_addr;
            m_wdata_q <= '0;
            m_be_q    <= 4'hF;
            state     <= ISSUE;
          end else if (data_win) begin
            owner     <= OWN_DATA;
            m_req_q   <= 1'b1;
            m_we_q    <= bus.d_we;
            m_addr_q  <= bus.d_addr;
            m_wdata_q <= bus.d_wdata;
            m_be_q    <= bus.d_be;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (tmo) begin
            m_req_q <= 1'b0;
            state   <= IDLE;
          end else if (bus.m_gnt) begin
            m_req_q <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (done) begin
            state <= IDLE;
          end
        end
        default: begin
          m_req_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  int passed = 0;
  int total  = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_LIMIT  (LIMIT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req    = 1'b0;
    bus.i_addr   = '0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.d_be     = '0;
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({busy, bus.m_req, bus.m_we, bus.m_be} !== 7'b0)
      $display("FAIL reset_ctl got=%b exp=0",
               {busy, bus.m_req, bus.m_we, bus.m_be});
    else passed++;
    total++;
    if ({bus.m_addr, bus.m_wdata} !== 64'h0)
      $display("FAIL reset_bus got=%h exp=0",
               {bus.m_addr, bus.m_wdata});
    else passed++;
    total++;
    if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid,
         bus.i_err, bus.d_err} !== 6'b0)
      $display("FAIL reset_rsp got=%b exp=0",
               {bus.i_gnt, bus.d_gnt, bus.i_rvalid,
                bus.d_rvalid, bus.i_err, bus.d_err});
    else passed++;
  endtask

  task automatic test_fetch_only();
    do_reset();
    step();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h8000_0000;
    bus.m_gnt  = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b10)
      $display("FAIL fetch_gnt got=%b exp=10",
               {bus.i_gnt, bus.d_gnt});
    else passed++;
    step();
    bus.i_req = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.m_req, bus.m_we, bus.m_be, bus.m_addr} !==
        {1'b1, 1'b0, 4'hF, 32'h8000_0000})
      $display("FAIL fetch_mreq got=%h exp=%h",
               {bus.m_req, bus.m_we, bus.m_be, bus.m_addr},
               {1'b1, 1'b0, 4'hF, 32'h8000_0000});
    else passed++;
    step();
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h0000_0013;
    @(negedge clk);
    total++;
    if ({bus.i_rvalid, bus.i_err, bus.d_rvalid, bus.i_rdata} !==
        {3'b100, 32'h0000_0013})
      $display("FAIL fetch_rsp got=%h exp=%h",
               {bus.i_rvalid, bus.i_err, bus.d_rvalid, bus.i_rdata},
               {3'b100, 32'h0000_0013});
    else passed++;
    step();
    bus.m_rvalid = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, bus.i_rvalid} !== 2'b00)
      $display("FAIL fetch_idle got=%b exp=00", {busy, bus.i_rvalid});
    else passed++;
  endtask

  task automatic test_store();
    do_reset();
    step();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h8000_1000;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_be    = 4'b0011;
    bus.m_gnt   = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b01)
      $display("FAIL store_gnt got=%b exp=01",
               {bus.i_gnt, bus.d_gnt});
    else passed++;
    step();
    bus.d_req = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.m_req, bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata} !==
        {1'b1, 1'b1, 4'b0011, 32'h8000_1000, 32'hDEAD_BEEF})
      $display("FAIL store_mreq got=%h exp=%h",
               {bus.m_req, bus.m_we, bus.m_be, bus.m_addr,
                bus.m_wdata},
               {1'b1, 1'b1, 4'b0011, 32'h8000_1000, 32'hDEAD_BEEF});
    else passed++;
    step();
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.d_rvalid, bus.d_err, bus.i_rvalid} !== 3'b100)
      $display("FAIL store_ack got=%b exp=100",
               {bus.d_rvalid, bus.d_err, bus.i_rvalid});
    else passed++;
    step();
    idle_inputs();
  endtask

  task automatic test_contention();
    string seq;
    string exp_seq;
    int    cnt;
    int    dbl;
    int    c;
    do_reset();
    exp_seq = "";
    cnt     = 0;
    for (int k = 0; k < 10; k++) begin
      if (cnt == LIMIT) begin
        exp_seq = {exp_seq, "I"};
        cnt     = 0;
      end else begin
        exp_seq = {exp_seq, "D"};
        cnt++;
      end
    end
    seq = "";
    dbl = 0;
    c   = 0;
    step();
    bus.i_req    = 1'b1;
    bus.i_addr   = 32'h8000_0040;
    bus.d_req    = 1'b1;
    bus.d_addr   = 32'h8000_1000;
    bus.d_be     = 4'hF;
    bus.m_gnt    = 1'b1;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h1234_5678;
    while (seq.len() < 10 && c < 60) begin
      @(negedge clk);
      if (bus.i_gnt && bus.d_gnt) dbl++;
      if (bus.i_gnt) seq = {seq, "I"};
      else if (bus.d_gnt) seq = {seq, "D"};
      c++;
      step();
    end
    idle_inputs();
    total++;
    if (seq != exp_seq)
      $display("FAIL contention_order got=%s exp=%s", seq, exp_seq);
    else passed++;
    total++;
    if (dbl !== 0)
      $display("FAIL contention_dbl_gnt got=%0d exp=0", dbl);
    else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    step();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h8000_2004;
    bus.d_be   = 4'hF;
    @(negedge clk);
    total++;
    if (bus.d_gnt !== 1'b1)
      $display("FAIL bp_gnt got=%b exp=1", bus.d_gnt);
    else passed++;
    step();
    bus.d_addr = 32'h8000_3000;
    bus.d_be   = 4'h5;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h8000_0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({bus.m_req, bus.m_addr, bus.m_be, bus.i_gnt, bus.d_gnt,
           busy} !== {1'b1, 32'h8000_2004, 4'hF, 3'b001})
        $display("FAIL bp_hold k=%0d got=%h exp=%h", k,
                 {bus.m_req, bus.m_addr, bus.m_be, bus.i_gnt,
                  bus.d_gnt, busy},
                 {1'b1, 32'h8000_2004, 4'hF, 3'b001});
      else passed++;
      step();
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.m_gnt = 1'b1;
    @(negedge clk);
    step();
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'hCAFE_0001;
    @(negedge clk);
    total++;
    if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'hCAFE_0001})
      $display("FAIL bp_rsp got=%h exp=%h",
               {bus.d_rvalid, bus.d_rdata}, {1'b1, 32'hCAFE_0001});
    else passed++;
    step();
    idle_inputs();
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    step();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h8000_0008;
    bus.d_be   = 4'hF;
    bus.m_gnt  = 1'b1;
    @(negedge clk);
    step();
    bus.d_req = 1'b0;
    @(negedge clk);
    step();
    bus.m_gnt = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b1)
      $display("FAIL rstw_busy_wait got=%b exp=1", busy);
    else passed++;
    step();
    rst          = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    total++;
    if ({bus.d_rvalid, bus.i_rvalid, busy} !== 3'b000)
      $display("FAIL rstw_ignore got=%b exp=000",
               {bus.d_rvalid, bus.i_rvalid, busy});
    else passed++;
    step();
    bus.m_rvalid = 1'b0;
    bus.d_req    = 1'b1;
    bus.d_addr   = 32'h8000_000C;
    @(negedge clk);
    total++;
    if ({bus.d_gnt, bus.m_req} !== 2'b10)
      $display("FAIL rstw_regnt got=%b exp=10",
               {bus.d_gnt, bus.m_req});
    else passed++;
    step();
    bus.d_req = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h8000_000C})
      $display("FAIL rstw_mreq got=%h exp=%h",
               {bus.m_req, bus.m_addr}, {1'b1, 32'h8000_000C});
    else passed++;
    step();
    idle_inputs();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    step();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h8000_0010;
    bus.d_be   = 4'hF;
    bus.m_gnt  = 1'b1;
    @(negedge clk);
    step();
    bus.d_req = 1'b0;
    @(negedge clk);
    for (int c = 2; c <= 1 + TMO; c++) begin
      step();
      bus.m_gnt   = 1'b0;
      bus.m_rdata = $urandom | 32'h1;
      @(negedge clk);
      total++;
      if (bus.d_rvalid !== (c == 1 + TMO))
        $display("FAIL tmo_rvalid cyc=%0d got=%b exp=%b",
                 c, bus.d_rvalid, (c == 1 + TMO));
      else passed++;
    end
    total++;
    if ({bus.d_err, bus.i_rvalid, bus.d_rdata} !== {2'b10, 32'h0})
      $display("FAIL tmo_err got=%h exp=%h",
               {bus.d_err, bus.i_rvalid, bus.d_rdata},
               {2'b10, 32'h0});
    else passed++;
    step();
    bus.m_rvalid = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.d_rvalid, busy} !== 2'b00)
      $display("FAIL tmo_late got=%b exp=00", {bus.d_rvalid, busy});
    else passed++;
    step();
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    logic [31:0] mem_bus [16];
    logic [31:0] mem_ref [16];
    bit          ip, dp, gen, in_flight, accepted, own_f, mo;
    bit          eig, edg, resp;
    logic        dwe, x_we;
    logic [31:0] ia, da, dwd, x_addr, x_wdata, x_exp, rd;
    logic [3:0]  dbe, x_be, m_idx, idx;
    int          starve, mdly, iss_wait, c;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      mem_bus[k] = $urandom;
      mem_ref[k] = mem_bus[k];
    end
    ip = 0; dp = 0; gen = 1; in_flight = 0; accepted = 0;
    own_f = 0; mo = 0; starve = 0; mdly = 0; iss_wait = 0;
    dwe = 0; x_we = 0; ia = 0; da = 0; dwd = 0; dbe = 0;
    x_addr = 0; x_wdata = 0; x_exp = 0; x_be = 0; m_idx = 0;
    c = 0;
    while (c < 600 && (gen || in_flight || ip || dp)) begin
      if (c == 450) gen = 0;
      step();
      if (gen && !ip && $urandom_range(0, 2) == 0) begin
        ip = 1;
        ia = 32'h8000_0000 |
             {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (gen && !dp && $urandom_range(0, 1) == 0) begin
        dp  = 1;
        dwe = 1'($urandom_range(0, 1));
        da  = 32'h8000_0000 |
              {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        dwd = $urandom;
        dbe = 4'($urandom_range(1, 15));
      end
      bus.i_req   = ip;
      bus.i_addr  = ia;
      bus.d_req   = dp;
      bus.d_we    = dwe;
      bus.d_addr  = da;
      bus.d_wdata = dwd;
      bus.d_be    = dbe;
      bus.m_gnt   = (iss_wait >= 2) || ($urandom_range(0, 1) == 1);
      if (mo && mdly == 0) begin
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = mem_bus[m_idx];
      end else begin
        if (mo) mdly--;
        bus.m_rvalid = !mo && ($urandom_range(0, 7) == 0);
        bus.m_rdata  = $urandom;
      end
      @(negedge clk);
      eig  = !in_flight && ip && (!dp || starve == LIMIT);
      edg  = !in_flight && dp && !eig;
      resp = in_flight && accepted && bus.m_rvalid;
      total++;
      if ({bus.i_gnt, bus.d_gnt} !== {eig, edg})
        $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c,
                 {bus.i_gnt, bus.d_gnt}, {eig, edg});
      else passed++;
      total++;
      if ({busy, bus.m_req} !== {in_flight, in_flight && !accepted})
        $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c,
                 {busy, bus.m_req},
                 {in_flight, in_flight && !accepted});
      else passed++;
      if (in_flight && !accepted) begin
        total++;
        if ({bus.m_we, bus.m_addr, bus.m_wdata, bus.m_be} !==
            {x_we, x_addr, x_wdata, x_be})
          $display("FAIL rnd_mbus cyc=%0d got=%h exp=%h", c,
                   {bus.m_we, bus.m_addr, bus.m_wdata, bus.m_be},
                   {x_we, x_addr, x_wdata, x_be});
        else passed++;
      end
      total++;
      if ({bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err} !==
          {resp && own_f, resp && !own_f, 2'b00})
        $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c,
                 {bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err},
                 {resp && own_f, resp && !own_f, 2'b00});
      else passed++;
      if (resp && !x_we) begin
        rd = own_f ? bus.i_rdata : bus.d_rdata;
        total++;
        if (rd !== x_exp)
          $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h",
                   c, rd, x_exp);
        else passed++;
      end
      if (!in_flight) begin
        if (!ip) starve = 0;
        if (eig) begin
          starve    = 0;
          in_flight = 1; accepted = 0; iss_wait = 0; own_f = 1;
          x_we = 0; x_addr = ia; x_wdata = 0; x_be = 4'hF;
          idx   = ia[5:2];
          x_exp = mem_ref[idx];
          ip    = 0;
        end else if (edg) begin
          if (ip && starve < LIMIT) starve++;
          in_flight = 1; accepted = 0; iss_wait = 0; own_f = 0;
          x_we = dwe; x_addr = da; x_wdata = dwd; x_be = dbe;
          idx   = da[5:2];
          x_exp = mem_ref[idx];
          if (dwe)
            for (int b = 0; b < 4; b++)
              if (dbe[b]) mem_ref[idx][8*b +: 8] = dwd[8*b +: 8];
          dp = 0;
        end
      end else if (!accepted) begin
        if (bus.m_gnt) begin
          accepted = 1;
          mo       = 1;
          mdly     = $urandom_range(0, 2);
          m_idx    = bus.m_addr[5:2];
          if (bus.m_we)
            for (int b = 0; b < 4; b++)
              if (bus.m_be[b])
                mem_bus[m_idx][8*b +: 8] = bus.m_wdata[8*b +: 8];
        end else begin
          iss_wait++;
        end
      end else if (resp) begin
        in_flight = 0;
        accepted  = 0;
        mo        = 0;
      end
      c++;
    end
    total++;
    if ({in_flight, ip, dp} !== 3'b000)
      $display("FAIL rnd_drain got=%b exp=000", {in_flight, ip, dp});
    else passed++;
    step();
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_store();
    test_contention();
    test_backpressure();
    test_reset_in_wait();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
